// File: rtl/memory_access_controller.sv
// memory_access_controller
// Sequences one word-aligned CPU read or write at a time onto the memory bus.
// An access ends either after a fixed number of cycles, or on MEM_ACK_In with
// a timeout. Completion is reported to the CPU with a one-cycle DONE pulse.
// Failed accesses (misaligned address or timeout) also pulse ERR with DONE.
// Every output is decoded from the state register and the capture registers.
// No output depends combinationally on an input.
module memory_access_controller #(
    parameter int DATAWIDTH_BUS  = 32,
    parameter int USE_ACK        = 0,
    parameter int WAIT_CYCLES    = 1,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                     MEMORY_ACCESS_CONTROLLER_CLOCK_50,
    input  logic                     MEMORY_ACCESS_CONTROLLER_RESET_InHigh,
    input  logic                     CPU_REQ_In,
    input  logic                     CPU_WE_In,
    input  logic [DATAWIDTH_BUS-1:0] CPU_ADDRESS_InBUS,
    input  logic [DATAWIDTH_BUS-1:0] CPU_data_InBUS,
    output logic                     CPU_READY_Out,
    output logic                     CPU_DONE_Out,
    output logic                     CPU_ERR_Out,
    output logic [DATAWIDTH_BUS-1:0] CPU_data_OutBUS,
    output logic [DATAWIDTH_BUS-1:0] MEM_ADDRESS_OutBUS,
    output logic [DATAWIDTH_BUS-1:0] MEM_data_OutBUS,
    output logic                     MEM_RD_Out,
    output logic                     MEM_WR_Out,
    input  logic [DATAWIDTH_BUS-1:0] MEM_data_InBUS,
    input  logic                     MEM_ACK_In
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2,
        S_ERR    = 2'd3
    } state_t;

    localparam logic       ACK_MODE    = (USE_ACK != 0);
    localparam logic [7:0] WAIT_LAST   = 8'(WAIT_CYCLES);
    localparam logic [7:0] TIMEOUT_LST = 8'(TIMEOUT_CYCLES);

    state_t                   r_state;
    logic                     r_we;
    logic [DATAWIDTH_BUS-1:0] r_addr;
    logic [DATAWIDTH_BUS-1:0] r_wdata;
    logic [DATAWIDTH_BUS-1:0] r_rdata;
    logic [7:0]               r_cnt;

    // r_cnt holds the number of ACCESS cycles already completed.
    // w_cnt_cur is therefore the 1-based index of the current ACCESS cycle.
    logic [7:0] w_cnt_cur;
    logic       w_finish;
    logic       w_timeout;
    logic       w_misaligned;

    assign w_cnt_cur    = r_cnt + 8'd1;
    assign w_misaligned = (CPU_ADDRESS_InBUS[1:0] != 2'b00);
    assign w_finish     = ACK_MODE ? MEM_ACK_In : (w_cnt_cur == WAIT_LAST);
    assign w_timeout    = ACK_MODE && (w_cnt_cur == TIMEOUT_LST);

    // Request capture, access sequencing and read-data latch.
    always_ff @(posedge MEMORY_ACCESS_CONTROLLER_CLOCK_50) begin
        if (MEMORY_ACCESS_CONTROLLER_RESET_InHigh) begin
            r_state <= S_IDLE;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_cnt   <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (CPU_REQ_In) begin
                        r_we    <= CPU_WE_In;
                        r_addr  <= CPU_ADDRESS_InBUS;
                        r_wdata <= CPU_data_InBUS;
                        r_cnt   <= 8'd0;
                        r_state <= w_misaligned ? S_ERR : S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    r_cnt <= w_cnt_cur;
                    // An acknowledge takes priority over a coincident timeout.
                    if (w_finish) begin
                        if (!r_we) begin
                            r_rdata <= MEM_data_InBUS;
                        end
                        r_state <= S_DONE;
                    end else if (w_timeout) begin
                        r_state <= S_ERR;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                S_ERR:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign CPU_READY_Out      = (r_state == S_IDLE);
    assign CPU_DONE_Out       = (r_state == S_DONE) || (r_state == S_ERR);
    assign CPU_ERR_Out        = (r_state == S_ERR);
    assign CPU_data_OutBUS    = r_rdata;
    assign MEM_ADDRESS_OutBUS = r_addr;
    assign MEM_data_OutBUS    = r_wdata;
    assign MEM_RD_Out         = (r_state == S_ACCESS) && !r_we;
    assign MEM_WR_Out         = (r_state == S_ACCESS) && r_we;

endmodule

// File: tb/tb_memory_access_controller.sv
// Testbench for memory_access_controller.
// Three instances share all stimulus:
//   u_fix : fixed latency, WAIT_CYCLES=1
//   u_ack : ACK mode, TIMEOUT_CYCLES=4
//   u_w3  : fixed latency, WAIT_CYCLES=3
// Each test observes only the instance it targets.
// A reset separates the test groups so that all instances start in IDLE.
module tb_memory_access_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mdata;
    logic        ack;

    logic        f_ready, f_done, f_err, f_rd, f_wr;
    logic [31:0] f_rdata, f_maddr, f_mdout;
    logic        a_ready, a_done, a_err, a_rd, a_wr;
    logic [31:0] a_rdata, a_maddr, a_mdout;
    logic        t_ready, t_done, t_err, t_rd, t_wr;
    logic [31:0] t_rdata, t_maddr, t_mdout;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    memory_access_controller #(.DATAWIDTH_BUS(32), .USE_ACK(0), .WAIT_CYCLES(1), .TIMEOUT_CYCLES(16)) u_fix (
        .MEMORY_ACCESS_CONTROLLER_CLOCK_50(clk), .MEMORY_ACCESS_CONTROLLER_RESET_InHigh(rst),
        .CPU_REQ_In(req), .CPU_WE_In(we), .CPU_ADDRESS_InBUS(addr), .CPU_data_InBUS(wdata),
        .CPU_READY_Out(f_ready), .CPU_DONE_Out(f_done), .CPU_ERR_Out(f_err), .CPU_data_OutBUS(f_rdata),
        .MEM_ADDRESS_OutBUS(f_maddr), .MEM_data_OutBUS(f_mdout), .MEM_RD_Out(f_rd), .MEM_WR_Out(f_wr),
        .MEM_data_InBUS(mdata), .MEM_ACK_In(ack));

    memory_access_controller #(.DATAWIDTH_BUS(32), .USE_ACK(1), .WAIT_CYCLES(1), .TIMEOUT_CYCLES(4)) u_ack (
        .MEMORY_ACCESS_CONTROLLER_CLOCK_50(clk), .MEMORY_ACCESS_CONTROLLER_RESET_InHigh(rst),
        .CPU_REQ_In(req), .CPU_WE_In(we), .CPU_ADDRESS_InBUS(addr), .CPU_data_InBUS(wdata),
        .CPU_READY_Out(a_ready), .CPU_DONE_Out(a_done), .CPU_ERR_Out(a_err), .CPU_data_OutBUS(a_rdata),
        .MEM_ADDRESS_OutBUS(a_maddr), .MEM_data_OutBUS(a_mdout), .MEM_RD_Out(a_rd), .MEM_WR_Out(a_wr),
        .MEM_data_InBUS(mdata), .MEM_ACK_In(ack));

    memory_access_controller #(.DATAWIDTH_BUS(32), .USE_ACK(0), .WAIT_CYCLES(3), .TIMEOUT_CYCLES(16)) u_w3 (
        .MEMORY_ACCESS_CONTROLLER_CLOCK_50(clk), .MEMORY_ACCESS_CONTROLLER_RESET_InHigh(rst),
        .CPU_REQ_In(req), .CPU_WE_In(we), .CPU_ADDRESS_InBUS(addr), .CPU_data_InBUS(wdata),
        .CPU_READY_Out(t_ready), .CPU_DONE_Out(t_done), .CPU_ERR_Out(t_err), .CPU_data_OutBUS(t_rdata),
        .MEM_ADDRESS_OutBUS(t_maddr), .MEM_data_OutBUS(t_mdout), .MEM_RD_Out(t_rd), .MEM_WR_Out(t_wr),
        .MEM_data_InBUS(mdata), .MEM_ACK_In(ack));

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mdata;
        int          lat;     // cycles from accept edge to the DONE cycle
        logic        err;
        int          rd_cyc;
        int          wr_cyc;
        logic [31:0] rdata;   // CPU_data_OutBUS expected in the DONE cycle
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; req = 1'b0; ack = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Issue one request at the next edge and return the accept edge's timing
    // context: the caller then samples the following cycles at negedges.
    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [31:0] m);
        req = 1'b1; we = w; addr = a; wdata = d; mdata = m;
        @(posedge clk); #1;
        req = 1'b0;
    endtask

    int lat, rdc, wrc;
    logic e;
    logic [31:0] rdv;

    initial begin
        rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; mdata = '0; ack = 1'b0;
        vecs[0] = '{1'b0, 32'h0000_0800, 32'h0000_0000, 32'h8210_2000, 2, 1'b0, 1, 0, 32'h8210_2000};
        vecs[1] = '{1'b1, 32'h0000_080C, 32'h1080_0004, 32'hDEAD_BEEF, 2, 1'b0, 0, 1, 32'h8210_2000};
        vecs[2] = '{1'b0, 32'h0000_0802, 32'h0000_0000, 32'h1111_1111, 1, 1'b1, 0, 0, 32'h8210_2000};
        vecs[3] = '{1'b1, 32'h0000_0811, 32'hCAFE_0001, 32'h2222_2222, 1, 1'b1, 0, 0, 32'h8210_2000};
        vecs[4] = '{1'b0, 32'h0000_0804, 32'h0000_0000, 32'hA5A5_5A5A, 2, 1'b0, 1, 0, 32'hA5A5_5A5A};
        vecs[5] = '{1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 32'hFFFF_FFFF, 2, 1'b0, 1, 0, 32'hFFFF_FFFF};

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state of the fixed-latency instance.
        @(negedge clk);
        check("reset_ready", 32'(f_ready), 32'd1);
        check("reset_rd",    32'(f_rd),    32'd0);
        check("reset_wr",    32'(f_wr),    32'd0);
        check("reset_done",  32'(f_done),  32'd0);
        check("reset_err",   32'(f_err),   32'd0);
        check("reset_rdata", f_rdata, 32'd0);
        check("reset_maddr", f_maddr, 32'd0);
        check("reset_mdout", f_mdout, 32'd0);

        // Table-driven single accesses on u_fix.
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check($sformatf("v%0d_ready", i), 32'(f_ready), 32'd1);
            issue(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].mdata);
            lat = 0; rdc = 0; wrc = 0; e = 1'b0; rdv = '0;
            for (int c = 1; c <= 8; c++) begin
                @(negedge clk);
                if (f_rd) rdc++;
                if (f_wr) wrc++;
                if (f_done) begin
                    lat = c; e = f_err; rdv = f_rdata;
                    break;
                end
            end
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("v%0d_err", i),     32'(e),   32'(vecs[i].err));
            check($sformatf("v%0d_rd_cycles", i), 32'(rdc), 32'(vecs[i].rd_cyc));
            check($sformatf("v%0d_wr_cycles", i), 32'(wrc), 32'(vecs[i].wr_cyc));
            check($sformatf("v%0d_rdata", i), rdv, vecs[i].rdata);
            check($sformatf("v%0d_maddr", i), f_maddr, vecs[i].addr);
            check($sformatf("v%0d_mdout", i), f_mdout, vecs[i].wdata);
            $display("vec %0d we=%0b addr=0x%08h lat=%0d err=%0b rdata=0x%08h", i, vecs[i].we, vecs[i].addr, lat, e, rdv);
        end

        // ACK mode: never acked, acked in cycle 2, ack coinciding with timeout.
        for (int k = 0; k < 3; k++) begin
            int ack_at;
            int exp_lat;
            logic exp_err;
            logic [31:0] exp_d;
            logic [31:0] m;
            do_reset();
            ack_at  = (k == 0) ? 0 : ((k == 1) ? 2 : 4);
            m       = 32'h1234_5670 + 32'(k);
            exp_lat = (k == 0) ? 5 : ack_at + 1;
            exp_err = (k == 0);
            exp_d   = (k == 0) ? 32'h0 : m;
            issue(1'b0, 32'h0000_0900, 32'h0, m);
            ack = (ack_at == 1);
            lat = 0; rdc = 0; e = 1'b0; rdv = '0;
            for (int c = 1; c <= 10; c++) begin
                @(negedge clk);
                if (a_rd) rdc++;
                if (a_done) begin
                    lat = c; e = a_err; rdv = a_rdata;
                    break;
                end
                @(posedge clk); #1;
                ack = (c + 1 == ack_at);
            end
            ack = 1'b0;
            check($sformatf("ack%0d_latency", k), 32'(lat), 32'(exp_lat));
            check($sformatf("ack%0d_err", k),     32'(e),   32'(exp_err));
            check($sformatf("ack%0d_rd_cycles", k), 32'(rdc), 32'(exp_lat - 1));
            check($sformatf("ack%0d_rdata", k), rdv, exp_d);
            $display("ack case %0d ack_at=%0d lat=%0d err=%0b rdata=0x%08h", k, ack_at, lat, e, rdv);
        end

        // Reset in the middle of a WAIT_CYCLES=3 read on u_w3.
        do_reset();
        issue(1'b0, 32'h0000_0820, 32'h0, 32'h5555_AAAA);
        @(negedge clk);
        check("w3_rd_c1", 32'(t_rd), 32'd1);
        @(negedge clk);
        check("w3_rd_c2", 32'(t_rd), 32'd1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("w3_rst_rd",    32'(t_rd),    32'd0);
        check("w3_rst_done",  32'(t_done),  32'd0);
        check("w3_rst_ready", 32'(t_ready), 32'd1);
        rdc = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (t_done || t_rd) rdc++;
        end
        check("w3_no_late_activity", 32'(rdc), 32'd0);
        $display("w3 reset mid-access: strobes dropped, ready=%0b", t_ready);
        @(posedge clk); #1;
        issue(1'b0, 32'h0000_0830, 32'h0, 32'h0BAD_F00D);
        lat = 0; rdc = 0; e = 1'b0; rdv = '0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (t_rd) rdc++;
            if (t_done) begin
                lat = c; e = t_err; rdv = t_rdata;
                break;
            end
        end
        check("w3_after_latency",   32'(lat), 32'd4);
        check("w3_after_rd_cycles", 32'(rdc), 32'd3);
        check("w3_after_err",       32'(e),   32'd0);
        check("w3_after_rdata",     rdv, 32'h0BAD_F00D);
        $display("w3 read 0x830 lat=%0d rdata=0x%08h", lat, rdv);

        // Back-to-back reads with CPU_REQ_In held high on u_fix.
        do_reset();
        begin
            int acc_cyc[3];
            logic [31:0] rd_addr[4];
            int nacc;
            int nrd;
            logic was_rd;
            nacc = 0; nrd = 0; was_rd = 1'b0;
            acc_cyc[0] = 0; acc_cyc[1] = 0; acc_cyc[2] = 0;
            rd_addr[0] = '0; rd_addr[1] = '0; rd_addr[2] = '0; rd_addr[3] = '0;
            req = 1'b1; we = 1'b0; addr = 32'h0000_0800; mdata = 32'h7777_0000;
            for (int c = 0; c < 20; c++) begin
                logic take;
                @(negedge clk);
                take = f_ready && req;
                if (take) acc_cyc[nacc] = c;
                if (f_rd) begin
                    if (nrd < 4) rd_addr[nrd] = f_maddr;
                    nrd++;
                end
                @(posedge clk); #1;
                if (take) begin
                    nacc++;
                    if (nacc == 3) req = 1'b0;
                    else addr = 32'h0000_0800 + 32'(4 * nacc);
                end
            end
            check("b2b_accepts",  32'(nacc), 32'd3);
            check("b2b_rd_cycles", 32'(nrd), 32'd3);
            check("b2b_spacing1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
            check("b2b_spacing2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd3);
            check("b2b_addr0", rd_addr[0], 32'h0000_0800);
            check("b2b_addr1", rd_addr[1], 32'h0000_0804);
            check("b2b_addr2", rd_addr[2], 32'h0000_0808);
            check("b2b_rdata", f_rdata, 32'h7777_0000);
            $display("b2b accepts=%0d rd_cycles=%0d at cycles %0d %0d %0d", nacc, nrd, acc_cyc[0], acc_cyc[1], acc_cyc[2]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Strobe exclusivity across every instance, every cycle.
    always @(negedge clk) begin
        if (!rst && ((f_rd && f_wr) || (a_rd && a_wr) || (t_rd && t_wr))) begin
            total++;
            bad++;
            $display("FAIL strobe_exclusive: rd and wr both high at %0t", $time);
        end
    end

endmodule

// File: doc/memory_access_controller.md
# memory_access_controller

Sequencing front end between the processor control unit and the main memory. It accepts one word-aligned read or write request at a time from the CPU and drives the memory address/data buses with an RD or WR strobe. It terminates the access on memory ACK or after a fixed wait, then returns read data to the CPU with a one-cycle completion pulse. It flags misaligned and timed-out accesses.

## Interface
Parameters:
- DATAWIDTH_BUS, 32, address and data width
- USE_ACK, 0, 0 = fixed-latency completion after WAIT_CYCLES; 1 = complete on MEM_ACK_In
- WAIT_CYCLES, 1, access-cycle count in fixed-latency mode; legal range 1..255
- TIMEOUT_CYCLES, 16, maximum access cycles in ACK mode before error; legal range 1..255

Ports:
- MEMORY_ACCESS_CONTROLLER_CLOCK_50  in  1  single clock; all state changes on rising edge
- MEMORY_ACCESS_CONTROLLER_RESET_InHigh  in  1  synchronous, active-high reset
- CPU_REQ_In  in  1  request; sampled only when CPU_READY_Out=1
- CPU_WE_In  in  1  1 = write, 0 = read; qualified by CPU_REQ_In
- CPU_ADDRESS_InBUS  in  DATAWIDTH_BUS  byte address of the access
- CPU_data_InBUS  in  DATAWIDTH_BUS  write data
- CPU_READY_Out  out  1  high in IDLE only
- CPU_DONE_Out  out  1  one-cycle completion pulse (success or error)
- CPU_ERR_Out  out  1  one-cycle pulse, coincident with CPU_DONE_Out on failed access
- CPU_data_OutBUS  out  DATAWIDTH_BUS  last successfully read word
- MEM_ADDRESS_OutBUS  out  DATAWIDTH_BUS  address to memory
- MEM_data_OutBUS  out  DATAWIDTH_BUS  write data to memory
- MEM_RD_Out  out  1  read strobe, active-high
- MEM_WR_Out  out  1  write strobe, active-high
- MEM_data_InBUS  in  DATAWIDTH_BUS  read data from memory
- MEM_ACK_In  in  1  access acknowledge; ignored when USE_ACK=0

## Operation
- The FSM has 4 states: IDLE, ACCESS, DONE, ERR. The state is registered, and all outputs are decoded from registered state and registers.
- IDLE: CPU_READY_Out=1. On CPU_REQ_In=1, capture the address, write data, and WE into registers, and clear the 8-bit access counter.
  - If CPU_ADDRESS_InBUS[1:0]≠00, go to ERR. No memory strobe is ever asserted.
  - Otherwise, go to ACCESS.
- ACCESS: MEM_RD_Out=~WE and MEM_WR_Out=WE, held continuously. MEM_ADDRESS_OutBUS and MEM_data_OutBUS come from the capture registers. The counter increments every ACCESS cycle, starting at 1 in the first cycle.
  - USE_ACK=0: at the edge ending the cycle where counter==WAIT_CYCLES, go to DONE. On a read, latch MEM_data_InBUS into CPU_data_OutBUS at that edge.
  - USE_ACK=1: at any edge with MEM_ACK_In=1, go to DONE, latching read data as above. Otherwise, if counter==TIMEOUT_CYCLES, go to ERR. If ACK and timeout coincide, ACK wins.
- DONE: CPU_DONE_Out=1 for one cycle, strobes low, then go to IDLE.
- ERR: CPU_DONE_Out=1 and CPU_ERR_Out=1 for one cycle, strobes low, then go to IDLE. CPU_data_OutBUS is unchanged.
- Writes never modify CPU_data_OutBUS.
- CPU_REQ_In outside IDLE is ignored. There is no queueing.
- MEM_ADDRESS_OutBUS and MEM_data_OutBUS change only on an accepted request and stay stable through DONE/ERR and IDLE.
- MEM_RD_Out and MEM_WR_Out are never high simultaneously.

## Timing
- Reset: state IDLE, counter 0. CPU_READY_Out=1.
  - Low after reset: MEM_RD_Out, MEM_WR_Out, CPU_DONE_Out, CPU_ERR_Out.
  - All data/address outputs are 0.
- Reset in any state forces IDLE at that edge. In the next cycle strobes are low, no DONE/ERR is issued, and the captured request is discarded.
- Fixed-latency mode, request accepted at edge k:
  - ACCESS occupies cycles k+1..k+WAIT_CYCLES.
  - DONE is in cycle k+WAIT_CYCLES+1.
  - READY returns in cycle k+WAIT_CYCLES+2.
  - With WAIT_CYCLES=1, the throughput is one access per 3 cycles.
- ACK mode:
  - ACK sampled in ACCESS cycle i gives DONE in the next cycle.
  - If ACK never arrives, ERR is in cycle k+TIMEOUT_CYCLES+1.
- Misaligned request: ERR in cycle k+1, zero strobe cycles.

## Test plan
- Reset, then read 0x00000800 with USE_ACK=0, WAIT_CYCLES=1, and memory returning 0x82102000:
  - RD high for exactly 1 cycle.
  - DONE 2 cycles after accept.
  - CPU_data_OutBUS=0x82102000.
  - ERR=0.
- Write 0x0000080C with data 0x10800004:
  - WR high for 1 cycle, RD never high.
  - MEM_data_OutBUS=0x10800004.
  - CPU_data_OutBUS keeps its previous read value.
- Read 0x00000802 (misaligned):
  - DONE and ERR pulse together 1 cycle after accept.
  - MEM_RD_Out never asserts.
- USE_ACK=1, TIMEOUT_CYCLES=4, ACK held low:
  - RD high for 4 cycles, then DONE+ERR.
  - Repeat with ACK high in the 2nd access cycle: DONE with no ERR, and the data is latched.
- Assert reset in the middle of a WAIT_CYCLES=3 read:
  - Strobes drop the next cycle, no DONE, READY=1.
  - A following read of 0x00000830 completes normally.
- Back-to-back requests with CPU_REQ_In held high for reads of 0x800, 0x804, 0x808:
  - Exactly 3 accesses at 3-cycle spacing.
  - No request is accepted while READY=0.
